// File: rtl/priority_bit_serializer_if.sv
// Request-word in / one-hot beat out handshake bundle for priority_bit_serializer.
// The serializer takes the slave side; the upstream/downstream pair takes master.
interface priority_bit_serializer_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] data_i;
    logic             data_val_i;
    logic             data_ready_o;
    logic [WIDTH-1:0] onehot_o;
    logic [IDX_W-1:0] index_o;
    logic             last_o;
    logic             empty_o;
    logic             data_val_o;
    logic             data_ready_i;

    modport slave (
        input  data_i,
        input  data_val_i,
        output data_ready_o,
        output onehot_o,
        output index_o,
        output last_o,
        output empty_o,
        output data_val_o,
        input  data_ready_i
    );

    modport master (
        output data_i,
        output data_val_i,
        input  data_ready_o,
        input  onehot_o,
        input  index_o,
        input  last_o,
        input  empty_o,
        input  data_val_o,
        output data_ready_i
    );
endinterface

// File: rtl/priority_bit_serializer.sv
// Expands a request word into one-hot beats, one per set bit, in priority order.
// One word in flight; a completing word can hand off to the next with no bubble.
module priority_bit_serializer #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    priority_bit_serializer_if.slave       bus
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             empty_q, empty_d;

    logic [WIDTH-1:0] scan_vec;
    logic [WIDTH-1:0] iso_vec;
    logic [WIDTH-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             last_c;
    logic             beat_fire_c;
    logic             ready_c;
    logic             accept_c;

    // Reverse the pending bits for MSB-first so one lowest-set-bit isolator serves both orders.
    for (genvar g = 0; g < WIDTH; g++) begin : g_order
        assign scan_vec[g] = MSB_FIRST ? remaining_q[WIDTH-1-g] : remaining_q[g];
        assign pick_oh[g]  = MSB_FIRST ? iso_vec[WIDTH-1-g]     : iso_vec[g];
    end

    assign iso_vec = scan_vec & (~scan_vec + WIDTH'(1));
    assign last_c  = ((remaining_q & (remaining_q - WIDTH'(1))) == '0);

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pick_oh[i]) begin
                pick_idx = pick_idx | IDX_W'(i);
            end
        end
    end

    // Handshake terms; ready also opens on the final beat of a word for zero-bubble reload.
    assign beat_fire_c = (state_q == ST_SCAN) && bus.data_ready_i;
    assign ready_c     = (state_q == ST_IDLE) || (beat_fire_c && last_c);
    assign accept_c    = bus.data_val_i && ready_c;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (beat_fire_c && last_c) begin
                    state_d = accept_c ? ST_SCAN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.data_ready_o = 1'b0;
        bus.data_val_o   = 1'b0;
        bus.onehot_o     = '0;
        bus.index_o      = '0;
        bus.last_o       = 1'b0;
        bus.empty_o      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.data_ready_o = 1'b1;
            end
            ST_SCAN: begin
                bus.data_ready_o = ready_c;
                bus.data_val_o   = 1'b1;
                bus.onehot_o     = pick_oh;
                bus.index_o      = pick_idx;
                bus.last_o       = last_c;
                bus.empty_o      = empty_q;
            end
            default: begin
                bus.data_ready_o = 1'b0;
            end
        endcase
    end

    // Pending-bit register: load on accept, otherwise retire the bit just issued.
    always_comb begin
        remaining_d = remaining_q;
        empty_d     = empty_q;
        if (accept_c) begin
            remaining_d = bus.data_i;
            empty_d     = (bus.data_i == '0);
        end else if (beat_fire_c) begin
            remaining_d = remaining_q & ~pick_oh;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            remaining_q <= '0;
            empty_q     <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            empty_q     <= empty_d;
        end
    end

endmodule
